// File: rtl/register_file_reader_pkg.sv
// Shared types and sizing constants for the integer register file.
//   REG_NUM      number of architectural registers (x0 reads as zero)
//   DATA_W       register width
//   PENDING_W    width of each per-register in-flight write counter
//   BasicData    one register value
//   RegAddr      register index
//   PendingCount one in-flight write counter
package register_file_reader_pkg;

  localparam int REG_NUM    = 32;
  localparam int DATA_W     = 32;
  localparam int PENDING_W  = 2;
  localparam int REG_ADDR_W = $clog2(REG_NUM);

  typedef logic [DATA_W-1:0]     BasicData;
  typedef logic [REG_ADDR_W-1:0] RegAddr;
  typedef logic [PENDING_W-1:0]  PendingCount;

endpackage

// File: rtl/register_file_reader_scoreboard.sv
// Per-register pending-write scoreboard producing the decode stall.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wb_en, wb_addr        writeback write enable and destination
//   rs1_addr, rs2_addr    decode source registers
//   rs1_used, rs2_used    decode actually reads the source
//   issue_valid           decode wants to issue this cycle
//   issue_writes_rd       issuing instruction writes a destination
//   issue_rd              destination of the issuing instruction
//   flush                 clears every counter on the edge
//   stall                 decode must hold
//   issued                issue_valid && !stall
module register_file_reader_scoreboard #(
  parameter int REG_NUM   = register_file_reader_pkg::REG_NUM,
  parameter int PENDING_W = register_file_reader_pkg::PENDING_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic [$clog2(REG_NUM)-1:0] wb_addr,
  input  logic [$clog2(REG_NUM)-1:0] rs1_addr,
  input  logic [$clog2(REG_NUM)-1:0] rs2_addr,
  input  logic                       rs1_used,
  input  logic                       rs2_used,
  input  logic                       issue_valid,
  input  logic                       issue_writes_rd,
  input  logic [$clog2(REG_NUM)-1:0] issue_rd,
  input  logic                       flush,
  output logic                       stall,
  output logic                       issued
);
  import register_file_reader_pkg::*;

  localparam int AW = $clog2(REG_NUM);

  logic [PENDING_W-1:0] cnt [REG_NUM];
  logic [REG_NUM-1:0]   wb_hit;
  logic [REG_NUM-1:0]   pending;
  logic [REG_NUM-1:0]   full;
  logic [REG_NUM-1:0]   inc;
  logic [REG_NUM-1:0]   dec;

  // A register is still pending when its count exceeds the writeback that
  // lands this very cycle, i.e. eff = cnt - wbHit (floored) is non-zero.
  always_comb begin
    wb_hit  = '0;
    pending = '0;
    full    = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      wb_hit[r]  = wb_en && (wb_addr == AW'(r));
      pending[r] = cnt[r] > {{(PENDING_W-1){1'b0}}, wb_hit[r]};
      full[r]    = &cnt[r];
    end
  end

  // Saturation guard: a full counter cannot absorb another writer.
  always_comb begin
    stall  = issue_valid &&
             ((rs1_used && pending[rs1_addr]) ||
              (rs2_used && pending[rs2_addr]) ||
              (issue_writes_rd && (issue_rd != '0) && full[issue_rd]));
    issued = issue_valid && !stall;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      inc[r] = issued && issue_writes_rd && (issue_rd == AW'(r));
      dec[r] = wb_hit[r] && (cnt[r] != '0);
    end
  end

  // Counter 0 is never incremented or decremented, so it stays at zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < REG_NUM; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + PENDING_W'(1);
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - PENDING_W'(1);
      end
    end
  end

endmodule

// File: rtl/register_file_reader.sv
// Architectural integer register file with two combinational read ports,
// write-to-read bypass from the writeback port, and the pending-write
// scoreboard that stalls decode.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wEnable, rdAddr, wData    writeback write port (writes to x0 dropped)
//   rs1Addr, rs2Addr          read addresses
//   rs1Used, rs2Used          decode actually reads the source
//   rs1Data, rs2Data          read data (x0 reads zero)
//   issueValid, issueWritesRd, issueRd   issue request from decode
//   flush                     clears all pending counters
//   stall, issued             decode hold / instruction issued
module register_file_reader #(
  parameter int REG_NUM   = register_file_reader_pkg::REG_NUM,
  parameter int DATA_W    = register_file_reader_pkg::DATA_W,
  parameter int PENDING_W = register_file_reader_pkg::PENDING_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wEnable,
  input  logic [$clog2(REG_NUM)-1:0] rdAddr,
  input  logic [DATA_W-1:0]          wData,
  input  logic [$clog2(REG_NUM)-1:0] rs1Addr,
  input  logic [$clog2(REG_NUM)-1:0] rs2Addr,
  input  logic                       rs1Used,
  input  logic                       rs2Used,
  output logic [DATA_W-1:0]          rs1Data,
  output logic [DATA_W-1:0]          rs2Data,
  input  logic                       issueValid,
  input  logic                       issueWritesRd,
  input  logic [$clog2(REG_NUM)-1:0] issueRd,
  input  logic                       flush,
  output logic                       stall,
  output logic                       issued
);
  import register_file_reader_pkg::*;

  logic [DATA_W-1:0] regs [REG_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else if (wEnable && (rdAddr != '0)) begin
      regs[rdAddr] <= wData;
    end
  end

  // Bypass the writeback value so decode sees it in the same cycle.
  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    if (rs1Addr != '0)
      rs1Data = (wEnable && (rdAddr == rs1Addr)) ? wData : regs[rs1Addr];
    if (rs2Addr != '0)
      rs2Data = (wEnable && (rdAddr == rs2Addr)) ? wData : regs[rs2Addr];
  end

  register_file_reader_scoreboard #(
    .REG_NUM   (REG_NUM),
    .PENDING_W (PENDING_W)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .wb_en           (wEnable),
    .wb_addr         (rdAddr),
    .rs1_addr        (rs1Addr),
    .rs2_addr        (rs2Addr),
    .rs1_used        (rs1Used),
    .rs2_used        (rs2Used),
    .issue_valid     (issueValid),
    .issue_writes_rd (issueWritesRd),
    .issue_rd        (issueRd),
    .flush           (flush),
    .stall           (stall),
    .issued          (issued)
  );

endmodule

// File: tb/tb_register_file_reader.sv
// Directed-vector bench for register_file_reader. The stimulus process drives
// one vector per cycle and queues its hand-computed expectation; a monitor
// process drains the queue on the falling edge and compares.
module tb_register_file_reader;
  import register_file_reader_pkg::*;

  logic     clk;
  logic     rst;
  logic     wEnable;
  RegAddr   rdAddr;
  BasicData wData;
  RegAddr   rs1Addr;
  RegAddr   rs2Addr;
  logic     rs1Used;
  logic     rs2Used;
  BasicData rs1Data;
  BasicData rs2Data;
  logic     issueValid;
  logic     issueWritesRd;
  RegAddr   issueRd;
  logic     flush;
  logic     stall;
  logic     issued;

  register_file_reader dut (
    .clk           (clk),
    .rst           (rst),
    .wEnable       (wEnable),
    .rdAddr        (rdAddr),
    .wData         (wData),
    .rs1Addr       (rs1Addr),
    .rs2Addr       (rs2Addr),
    .rs1Used       (rs1Used),
    .rs2Used       (rs2Used),
    .rs1Data       (rs1Data),
    .rs2Data       (rs2Data),
    .issueValid    (issueValid),
    .issueWritesRd (issueWritesRd),
    .issueRd       (issueRd),
    .flush         (flush),
    .stall         (stall),
    .issued        (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bit 0: check rs1Data, bit 1: rs2Data, bit 2: stall and issued
  typedef struct {
    string    name;
    logic [2:0] mask;
    BasicData d1;
    BasicData d2;
    logic     st;
    logic     iss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] M_D1 = 3'b001;
  localparam logic [2:0] M_D2 = 3'b010;
  localparam logic [2:0] M_ST = 3'b100;

  task automatic expect_vec(input string name, input logic [2:0] mask,
                            input BasicData d1, input BasicData d2,
                            input logic st, input logic iss);
    exp_t e;
    e.name = name; e.mask = mask; e.d1 = d1; e.d2 = d2; e.st = st; e.iss = iss;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wEnable = 0; rdAddr = '0; wData = '0;
    rs1Addr = '0; rs2Addr = '0; rs1Used = 0; rs2Used = 0;
    issueValid = 0; issueWritesRd = 0; issueRd = '0; flush = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue_writer(input RegAddr rd);
    issueValid = 1; issueWritesRd = 1; issueRd = rd;
  endtask

  task automatic reader1(input RegAddr a);
    issueValid = 1; rs1Used = 1; rs1Addr = a;
  endtask

  task automatic wb(input RegAddr a, input BasicData d);
    wEnable = 1; rdAddr = a; wData = d;
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.mask[0]) begin
          checks++;
          if (rs1Data !== e.d1) begin
            errors++;
            $display("FAIL %s rs1Data got %h want %h", e.name, rs1Data, e.d1);
          end
        end
        if (e.mask[1]) begin
          checks++;
          if (rs2Data !== e.d2) begin
            errors++;
            $display("FAIL %s rs2Data got %h want %h", e.name, rs2Data, e.d2);
          end
        end
        if (e.mask[2]) begin
          checks++;
          if (stall !== e.st) begin
            errors++;
            $display("FAIL %s stall got %b want %b", e.name, stall, e.st);
          end
          checks++;
          if (issued !== e.iss) begin
            errors++;
            $display("FAIL %s issued got %b want %b", e.name, issued, e.iss);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;

    // Reset state: reads of x5/x0 are zero, nothing pending.
    rs1Addr = 5; rs2Addr = 0; rs1Used = 1; rs2Used = 1; issueValid = 1;
    expect_vec("reset_read", M_D1 | M_D2 | M_ST, 32'h0, 32'h0, 0, 1);
    nxt();

    // Bypass then stored value; x0 write dropped.
    wb(5, 32'hDEADBEEF); rs1Addr = 5;
    expect_vec("bypass_x5", M_D1 | M_ST, 32'hDEADBEEF, 32'h0, 0, 0);
    nxt();
    wb(0, 32'h1234); rs1Addr = 5; rs2Addr = 0;
    expect_vec("stored_x5_x0", M_D1 | M_D2, 32'hDEADBEEF, 32'h0, 0, 0);
    nxt();

    // Writer then reader of x7; writeback releases the same cycle.
    issue_writer(7);
    expect_vec("writer_x7", M_ST, 32'h0, 32'h0, 0, 1);
    nxt();
    reader1(7);
    expect_vec("reader_x7_stall", M_ST, 32'h0, 32'h0, 1, 0);
    nxt();
    reader1(7); wb(7, 32'h55);
    expect_vec("reader_x7_wb", M_D1 | M_ST, 32'h55, 32'h0, 0, 1);
    nxt();
    reader1(7);
    expect_vec("reader_x7_after", M_D1 | M_ST, 32'h55, 32'h0, 0, 1);
    nxt();

    // Three writers to x3 fill the counter; a fourth is held.
    for (int i = 0; i < 3; i++) begin
      issue_writer(3);
      expect_vec($sformatf("writer_x3_%0d", i), M_ST, 32'h0, 32'h0, 0, 1);
      nxt();
    end
    issue_writer(3);
    expect_vec("writer_x3_full", M_ST, 32'h0, 32'h0, 1, 0);
    nxt();
    reader1(3); wb(3, 32'h33);
    expect_vec("x3_wb1", M_ST, 32'h0, 32'h0, 1, 0);
    nxt();
    reader1(3); wb(3, 32'h34);
    expect_vec("x3_wb2", M_ST, 32'h0, 32'h0, 1, 0);
    nxt();
    reader1(3); wb(3, 32'h35);
    expect_vec("x3_wb3", M_D1 | M_ST, 32'h35, 32'h0, 0, 1);
    nxt();

    // Simultaneous inc and dec on x9 leaves the count at 1.
    issue_writer(9);
    expect_vec("writer_x9", M_ST, 32'h0, 32'h0, 0, 1);
    nxt();
    issue_writer(9); wb(9, 32'h99);
    expect_vec("x9_inc_dec", M_ST, 32'h0, 32'h0, 0, 1);
    nxt();
    issueValid = 1; rs2Used = 1; rs2Addr = 9;
    expect_vec("x9_still1", M_D2 | M_ST, 32'h0, 32'h99, 1, 0);
    nxt();
    issueValid = 1; rs2Used = 1; rs2Addr = 9; wb(9, 32'h9A);
    expect_vec("x9_release", M_D2 | M_ST, 32'h0, 32'h9A, 0, 1);
    nxt();

    // Flush clears x4 (count 2) but not this cycle's stall; data write survives.
    issue_writer(4);
    nxt();
    issue_writer(4);
    expect_vec("writer_x4_2", M_ST, 32'h0, 32'h0, 0, 1);
    nxt();
    reader1(4); flush = 1; wb(12, 32'hAB);
    expect_vec("flush_cycle", M_ST, 32'h0, 32'h0, 1, 0);
    nxt();
    reader1(4); rs2Addr = 12;
    expect_vec("after_flush", M_D2 | M_ST, 32'h0, 32'hAB, 0, 1);
    nxt();
    reader1(4); wb(4, 32'h77);
    expect_vec("late_wb_x4", M_D1 | M_ST, 32'h77, 32'h0, 0, 1);
    nxt();
    reader1(4);
    expect_vec("x4_no_underflow", M_D1 | M_ST, 32'h77, 32'h0, 0, 1);
    nxt();

    // Instruction reading and writing x10 stalls only on its source.
    reader1(10); issueWritesRd = 1; issueRd = 10;
    expect_vec("rs1_eq_rd", M_ST, 32'h0, 32'h0, 0, 1);
    nxt();
    issue_writer(11);
    nxt();

    // Reset beats pending writes and a concurrent write.
    rst = 1; wb(5, 32'hFFFF_FFFF); issue_writer(6);
    nxt();
    rst = 0;
    rs1Addr = 5; rs2Addr = 10; rs2Used = 1; issueValid = 1;
    expect_vec("post_rst_a", M_D1 | M_D2 | M_ST, 32'h0, 32'h0, 0, 1);
    nxt();
    reader1(11); rs2Addr = 4;
    expect_vec("post_rst_b", M_D1 | M_D2 | M_ST, 32'h0, 32'h0, 0, 1);
    nxt();

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
